// File: rtl/counter_datapath_if.sv
// Control-to-datapath bundle for the 10000-counter: run/stop, clear, mode in;
// packed BCD digits and tick/wrap status pulses out.
interface counter_datapath_if;
  logic        i_mode;
  logic        i_run_stop;
  logic        i_clear;
  logic [15:0] o_bcd;
  logic        o_tick;
  logic        o_wrap;

  // Control FSM / bench side
  modport master (
    output i_mode, i_run_stop, i_clear,
    input  o_bcd, o_tick, o_wrap
  );

  // Datapath side
  modport slave (
    input  i_mode, i_run_stop, i_clear,
    output o_bcd, o_tick, o_wrap
  );
endinterface

// File: rtl/counter_datapath.sv
// Prescaled 4-digit cascaded BCD up/down counter (0000..9999) with tick and
// wrap status pulses for the display formatter.
// Optional build macro COUNTER_SATURATE_EN: pin at 9999 (up) / 0000 (down)
// instead of wrapping; o_wrap then flags each step that hits the boundary.
module counter_datapath #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned PRESC_W  = 20
) (
  input logic               clk,
  input logic               reset,
  counter_datapath_if.slave bus
);

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               tick_q;
  logic               wrap_q;

  logic [BCD_W-1:0]   bcd_roll_c;
  logic [BCD_W-1:0]   bcd_step_c;
  logic               carry_c;
  logic               cross_c;
  logic               terminal_c;

  assign terminal_c = (presc_q == PRESC_LAST);

  // One cascaded BCD step; a carry/borrow surviving all digits is a boundary crossing.
  always_comb begin
    bcd_roll_c = bcd_q;
    carry_c    = 1'b1;
    cross_c    = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry_c) begin
        if (!bus.i_mode) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_roll_c[4*i +: 4] = 4'd0;
          end else begin
            bcd_roll_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry_c              = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            bcd_roll_c[4*i +: 4] = 4'd9;
          end else begin
            bcd_roll_c[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            carry_c              = 1'b0;
          end
        end
      end
    end
    cross_c = carry_c;
  end

  // Boundary policy: wrap around, or stay pinned when saturation is built in.
  always_comb begin
    bcd_step_c = bcd_roll_c;
`ifdef COUNTER_SATURATE_EN
    if (cross_c) begin
      bcd_step_c = bcd_q;
    end
`endif
  end

  // Prescaler, counter and status pulses; priority clear > run > hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.i_clear) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.i_run_stop) begin
      if (terminal_c) begin
        presc_q <= '0;
        bcd_q   <= bcd_step_c;
        tick_q  <= 1'b1;
        wrap_q  <= cross_c;
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.o_bcd  = bcd_q;
  assign bus.o_tick = tick_q;
  assign bus.o_wrap = wrap_q;

endmodule
